// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: pulses RESET, qualifies LOCK, releases sys_rst_n and applies phase steps.
// Optional timeout restart in WAIT_LOCK/STABLE is enabled by defining PLL_SEQ_TIMEOUT_EN.
module pll_lock_sequencer #(
    parameter int unsigned RESET_PULSE_CYCLES  = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
    parameter int unsigned PHASE_SETTLE_CYCLES = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
    parameter logic [3:0]  FDLY_VAL            = 4'b0000
) (
    input  logic       clkin,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       pll_resetp,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    output logic [3:0] fdly,
    input  logic       phase_req,
    input  logic [3:0] phase_val,
    output logic       phase_ack,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [7:0] retry_cnt
);
    localparam int unsigned RST_W    = $clog2(RESET_PULSE_CYCLES + 1);
    localparam int unsigned STAB_W   = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(PHASE_SETTLE_CYCLES + 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_PHASE
    } state_e;

    state_e              state_q, state_d;
    logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [STAB_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif
    logic                lock_meta_q, lock_s_q;
    logic                pll_reset_q, pll_reset_d;
    logic                pll_resetp_q, pll_resetp_d;
    logic [3:0]          psda_q, psda_d;
    logic [3:0]          dutyda_q, dutyda_d;
    logic [3:0]          fdly_q, fdly_d;
    logic                phase_ack_q, phase_ack_d;
    logic                sys_rst_n_q, sys_rst_n_d;
    logic                locked_q, locked_d;
    logic [7:0]          retry_cnt_q, retry_cnt_d;
    logic                restart;

    // Next-state and registered-output logic; restart overrides any transition chosen below it.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        stab_cnt_d   = stab_cnt_q;
        settle_cnt_d = settle_cnt_q;
`ifdef PLL_SEQ_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        pll_reset_d  = pll_reset_q;
        pll_resetp_d = 1'b0;
        psda_d       = psda_q;
        dutyda_d     = dutyda_q;
        fdly_d       = FDLY_VAL;
        phase_ack_d  = 1'b0;
        sys_rst_n_d  = sys_rst_n_q;
        locked_d     = locked_q;
        retry_cnt_d  = retry_cnt_q;
        restart      = 1'b0;

        case (state_q)
            ST_RST_PLL: begin
                if (rst_cnt_q == RST_W'(RESET_PULSE_CYCLES - 1)) begin
                    state_d     = ST_WAIT_LOCK;
                    pll_reset_d = 1'b0;
`ifdef PLL_SEQ_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d    = ST_STABLE;
                    stab_cnt_d = '0;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stab_cnt_q == STAB_W'(LOCK_STABLE_CYCLES)) begin
                    state_d     = ST_RUN;
                    sys_rst_n_d = 1'b1;
                    locked_d    = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end
            end
            ST_RUN: begin
                // The request still held during the ack cycle is the one just served.
                if (!lock_s_q) begin
                    restart = 1'b1;
                end else if (phase_req && !phase_ack_q) begin
                    psda_d       = phase_val;
                    dutyda_d     = phase_val + 4'd8;
                    settle_cnt_d = '0;
                    state_d      = ST_PHASE;
                end
            end
            ST_PHASE: begin
                if (!lock_s_q) begin
                    restart = 1'b1;
                end else if (settle_cnt_q == SETTLE_W'(PHASE_SETTLE_CYCLES - 1)) begin
                    state_d     = ST_RUN;
                    phase_ack_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            default: restart = 1'b1;
        endcase

`ifdef PLL_SEQ_TIMEOUT_EN
        if (state_q == ST_WAIT_LOCK || state_q == ST_STABLE) begin
            if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                restart = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        if (restart) begin
            state_d     = ST_RST_PLL;
            rst_cnt_d   = '0;
            pll_reset_d = 1'b1;
            sys_rst_n_d = 1'b0;
            locked_d    = 1'b0;
            if (retry_cnt_q != 8'hFF) begin
                retry_cnt_d = retry_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state_q      <= ST_RST_PLL;
            rst_cnt_q    <= '0;
            stab_cnt_q   <= '0;
            settle_cnt_q <= '0;
`ifdef PLL_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_reset_q  <= 1'b1;
            pll_resetp_q <= 1'b0;
            psda_q       <= 4'd0;
            dutyda_q     <= 4'd8;
            fdly_q       <= FDLY_VAL;
            phase_ack_q  <= 1'b0;
            sys_rst_n_q  <= 1'b0;
            locked_q     <= 1'b0;
            retry_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            settle_cnt_q <= settle_cnt_d;
`ifdef PLL_SEQ_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
            lock_meta_q  <= pll_lock;
            lock_s_q     <= lock_meta_q;
            pll_reset_q  <= pll_reset_d;
            pll_resetp_q <= pll_resetp_d;
            psda_q       <= psda_d;
            dutyda_q     <= dutyda_d;
            fdly_q       <= fdly_d;
            phase_ack_q  <= phase_ack_d;
            sys_rst_n_q  <= sys_rst_n_d;
            locked_q     <= locked_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_resetp = pll_resetp_q;
    assign psda       = psda_q;
    assign dutyda     = dutyda_q;
    assign fdly       = fdly_q;
    assign phase_ack  = phase_ack_q;
    assign sys_rst_n  = sys_rst_n_q;
    assign locked     = locked_q;
    assign retry_cnt  = retry_cnt_q;

endmodule
